// File: rtl/dstack_engine.sv
// Data stack: top three entries in flops, deeper entries spilled to a register array.
// Latency: 1 cycle, one step per cycle; backpressure: none, illegal steps are dropped and flagged.
module dstack_engine #(
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  step,
    input  logic [1:0]            movement,
    input  logic [WORD_WIDTH-1:0] next_top,
    input  logic                  flush,
    input  logic                  clear_err,
    output logic [WORD_WIDTH-1:0] top,
    output logic [WORD_WIDTH-1:0] second,
    output logic [WORD_WIDTH-1:0] third,
    output logic [CW-1:0]         count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int RAM_N = DEPTH - 3;
    localparam int AW    = (RAM_N > 1) ? $clog2(RAM_N) : 1;

    localparam logic [1:0] MV_REPLACE = 2'b00;
    localparam logic [1:0] MV_PUSH    = 2'b01;
    localparam logic [1:0] MV_POP     = 2'b10;
    localparam logic [1:0] MV_POP2    = 2'b11;

    localparam logic [CW-1:0] C1     = CW'(1);
    localparam logic [CW-1:0] C2     = CW'(2);
    localparam logic [CW-1:0] C3     = CW'(3);
    localparam logic [CW-1:0] C4     = CW'(4);
    localparam logic [CW-1:0] C5     = CW'(5);
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    logic [WORD_WIDTH-1:0] ram [RAM_N];

    logic [AW-1:0]         a_spill;
    logic [AW-1:0]         a_fill4;
    logic [AW-1:0]         a_fill5;
    logic [WORD_WIDTH-1:0] fill4;
    logic [WORD_WIDTH-1:0] fill5;
    logic                  legal;
    logic                  accept;
    logic                  reject;
    logic                  do_spill;

    // Index arithmetic wraps modulo 2**AW; out-of-range reads only occur when
    // the count guard below discards them.
    assign a_spill = AW'(count) - AW'(3);
    assign a_fill4 = AW'(count) - AW'(4);
    assign a_fill5 = AW'(count) - AW'(5);

    assign fill4 = (count >= C4) ? ram[a_fill4] : '0;
    assign fill5 = (count >= C5) ? ram[a_fill5] : '0;

    always_comb begin
        legal = 1'b0;
        case (movement)
            MV_REPLACE: legal = (count >= C1);
            MV_PUSH:    legal = (count < C_FULL);
            MV_POP:     legal = (count >= C2);
            MV_POP2:    legal = (count >= C3);
            default:    legal = 1'b0;
        endcase
    end

    assign accept   = step && !flush && legal;
    assign reject   = step && !flush && !legal;
    assign do_spill = accept && (movement == MV_PUSH) && (count >= C3);

    always_ff @(posedge clk) begin
        if (!reset && do_spill) begin
            ram[a_spill] <= third;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            top    <= '0;
            second <= '0;
            third  <= '0;
            count  <= '0;
        end else if (accept) begin
            top <= next_top;
            case (movement)
                MV_PUSH: begin
                    second <= top;
                    third  <= second;
                    count  <= count + C1;
                end
                MV_POP: begin
                    second <= third;
                    third  <= fill4;
                    count  <= count - C1;
                end
                MV_POP2: begin
                    second <= fill4;
                    third  <= fill5;
                    count  <= count - C2;
                end
                default: begin
                end
            endcase
        end
    end

    // A rejected step in the same cycle as clear_err leaves its flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (clear_err) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
            if (reject) begin
                if (movement == MV_PUSH) overflow  <= 1'b1;
                else                     underflow <= 1'b1;
            end
        end
    end

    assign empty = (count == '0);
    assign full  = (count == C_FULL);

endmodule

// File: tb/tb_dstack_engine.sv
// Directed bench for dstack_engine: expected states queued at issue, compared by a separate monitor.
module tb_dstack_engine;

    typedef struct packed {
        logic [31:0] top;
        logic [31:0] second;
        logic [31:0] third;
        logic [4:0]  count;
        logic        empty;
        logic        full;
        logic        ovf;
        logic        unf;
    } st_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        step = 1'b0;
    logic [1:0]  movement = 2'b00;
    logic [31:0] next_top = '0;
    logic        flush = 1'b0;
    logic        clear_err = 1'b0;
    logic [31:0] top, second, third;
    logic [4:0]  count;
    logic        empty, full, overflow, underflow;

    st_t   exp_q [$];
    string name_q [$];
    int    n_chk = 0;
    int    n_pass = 0;

    localparam logic [1:0] REP = 2'b00, PUSH = 2'b01, POP = 2'b10, POP2 = 2'b11;

    dstack_engine dut (
        .clk(clk), .reset(reset), .step(step), .movement(movement),
        .next_top(next_top), .flush(flush), .clear_err(clear_err),
        .top(top), .second(second), .third(third), .count(count),
        .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    function automatic st_t mk(input logic [31:0] t, input logic [31:0] s, input logic [31:0] th,
                               input int c, input logic ov, input logic un);
        st_t m;
        m.top = t; m.second = s; m.third = th; m.count = 5'(c);
        m.empty = (c == 0); m.full = (c == 16); m.ovf = ov; m.unf = un;
        return m;
    endfunction

    task automatic cyc(input string nm, input logic rs, input logic fl, input logic ce,
                       input logic st, input logic [1:0] mv, input logic [31:0] nt, input st_t e);
        @(negedge clk);
        reset = rs; flush = fl; clear_err = ce; step = st; movement = mv; next_top = nt;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
    endtask

    // Monitor: the DUT presents a new state after every edge.
    initial begin
        st_t   e, a;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = '{top, second, third, count, empty, full, overflow, underflow};
                n_chk++;
                if (a === e) n_pass++;
                else $display("FAIL %s: got top=%h sec=%h thd=%h cnt=%0d emp=%b ful=%b ovf=%b unf=%b, want top=%h sec=%h thd=%h cnt=%0d emp=%b ful=%b ovf=%b unf=%b",
                              nm, a.top, a.second, a.third, a.count, a.empty, a.full, a.ovf, a.unf,
                              e.top, e.second, e.third, e.count, e.empty, e.full, e.ovf, e.unf);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        int wait_cyc;
        cyc("reset", 1, 0, 0, 0, REP, 0, mk(0, 0, 0, 0, 0, 0));
        cyc("reset_hold", 1, 0, 0, 1, PUSH, 32'h99, mk(0, 0, 0, 0, 0, 0));

        for (int k = 1; k <= 6; k++)
            cyc($sformatf("push_%0d", k), 0, 0, 0, 1, PUSH, 32'(k),
                mk(32'(k), (k >= 2) ? 32'(k - 1) : 0, (k >= 3) ? 32'(k - 2) : 0, k, 0, 0));

        cyc("pop_fill", 0, 0, 0, 1, POP, 32'hA, mk(32'hA, 4, 3, 5, 0, 0));
        cyc("pop2_fill", 0, 0, 0, 1, POP2, 32'hB, mk(32'hB, 2, 1, 3, 0, 0));
        cyc("replace_nostep", 0, 0, 0, 0, REP, 32'h55, mk(32'hB, 2, 1, 3, 0, 0));
        cyc("replace", 0, 0, 0, 1, REP, 32'h55, mk(32'h55, 2, 1, 3, 0, 0));

        for (int k = 4; k <= 16; k++)
            cyc($sformatf("fill_%0d", k), 0, 0, 0, 1, PUSH, 32'h100 + 32'(k),
                mk(32'h100 + 32'(k),
                   (k == 4) ? 32'h55 : 32'h100 + 32'(k - 1),
                   (k == 4) ? 32'h2 : (k == 5) ? 32'h55 : 32'h100 + 32'(k - 2), k, 0, 0));

        cyc("push_full", 0, 0, 0, 1, PUSH, 32'h999, mk(32'h110, 32'h10F, 32'h10E, 16, 1, 0));
        cyc("clear_ovf", 0, 0, 1, 0, REP, 0, mk(32'h110, 32'h10F, 32'h10E, 16, 0, 0));
        cyc("pop2_deep", 0, 0, 0, 1, POP2, 32'h200, mk(32'h200, 32'h10D, 32'h10C, 14, 0, 0));
        cyc("pop_deep", 0, 0, 0, 1, POP, 32'h201, mk(32'h201, 32'h10C, 32'h10B, 13, 0, 0));

        cyc("flush_push", 0, 1, 0, 1, PUSH, 32'h77, mk(0, 0, 0, 0, 0, 0));
        cyc("pop_empty", 0, 0, 0, 1, POP, 32'h1, mk(0, 0, 0, 0, 0, 1));
        cyc("push_7", 0, 0, 0, 1, PUSH, 32'h7, mk(7, 0, 0, 1, 0, 1));
        cyc("pop2_cnt1", 0, 0, 0, 1, POP2, 32'h3, mk(7, 0, 0, 1, 0, 1));
        cyc("clr_and_set", 0, 0, 1, 1, POP, 32'h3, mk(7, 0, 0, 1, 0, 1));
        cyc("push_8", 0, 0, 0, 1, PUSH, 32'h8, mk(8, 7, 0, 2, 0, 1));
        cyc("flush_keepflag", 0, 1, 0, 1, PUSH, 32'h9, mk(0, 0, 0, 0, 0, 1));
        cyc("push_a1", 0, 0, 0, 1, PUSH, 32'hA1, mk(32'hA1, 0, 0, 1, 0, 1));
        cyc("push_a2", 0, 0, 0, 1, PUSH, 32'hA2, mk(32'hA2, 32'hA1, 0, 2, 0, 1));
        cyc("reset_mid", 1, 0, 0, 1, PUSH, 32'hA3, mk(0, 0, 0, 0, 0, 0));
        cyc("push_after_rst", 0, 0, 0, 1, PUSH, 32'hC, mk(32'hC, 0, 0, 1, 0, 0));
        cyc("replace_cnt1", 0, 0, 0, 1, REP, 32'hD, mk(32'hD, 0, 0, 1, 0, 0));
        cyc("pop_cnt1", 0, 0, 0, 1, POP, 32'hE, mk(32'hD, 0, 0, 1, 0, 1));
        cyc("clear_unf", 0, 0, 1, 0, REP, 0, mk(32'hD, 0, 0, 1, 0, 0));
        cyc("flush2", 0, 1, 0, 0, REP, 0, mk(0, 0, 0, 0, 0, 0));
        cyc("replace_empty", 0, 0, 0, 1, REP, 32'hE, mk(0, 0, 0, 0, 0, 1));
        cyc("push_1", 0, 0, 0, 1, PUSH, 32'h1, mk(1, 0, 0, 1, 0, 1));
        cyc("push_2", 0, 0, 0, 1, PUSH, 32'h2, mk(2, 1, 0, 2, 0, 1));
        cyc("pop_cnt2", 0, 0, 0, 1, POP, 32'hF, mk(32'hF, 0, 0, 1, 0, 1));
        cyc("push_3", 0, 0, 0, 1, PUSH, 32'h3, mk(3, 32'hF, 0, 2, 0, 1));
        cyc("push_4", 0, 0, 0, 1, PUSH, 32'h4, mk(4, 3, 32'hF, 3, 0, 1));
        cyc("pop2_cnt3", 0, 0, 0, 1, POP2, 32'h5, mk(5, 0, 0, 1, 0, 1));

        @(negedge clk);
        step = 1'b0; clear_err = 1'b0; flush = 1'b0; reset = 1'b0;
        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (exp_q.size() > 0) begin
            n_chk++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
